biaspool_shuffler: RTL and testbench

Generates a random permutation of the one-hot values of width `w` and writes it, entry by entry, into the shuffle pool of a row-bias bus. It is the writer for the pool that the row-bias bus reads through one-hot `rqindex`, re-run after every reset or on demand. It sits between the global seed/control logic and each row's bias pool. Pool entries `0..w-1` receive the permutation; entry `w` always receives the all-zero special value.

---
 rtl/biaspool_shuffler_if.sv | 20 ++
 rtl/biaspool_shuffler.sv | 117 +++++++++++
 tb/tb_biaspool_shuffler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/biaspool_shuffler_if.sv
// Write-side bundle between the seed/control logic, the shuffler and a row bias pool.
// master: the shuffler; slave: whoever drives start/seed and observes the pool writes.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

interface biaspool_shuffler_if #(
  parameter int unsigned w = `GRID_LEN
) ();
  logic         start;
  logic [15:0]  seed;
  logic         busy;
  logic         done;
  logic         wr_en;
  logic [w:0]   wr_index;
  logic [w-1:0] wr_value;

  modport master (input start, seed, output busy, done, wr_en, wr_index, wr_value);
  modport slave  (output start, seed, input busy, done, wr_en, wr_index, wr_value);
endinterface

// File: rtl/biaspool_shuffler.sv
// Fisher-Yates shuffle of the w one-hot values driven by a 16-bit LFSR, then written
// entry by entry into the bias pool; entry w always receives zero.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module biaspool_shuffler #(
  parameter int unsigned w = `GRID_LEN
) (
  input  logic                clock,
  input  logic                reset,
  biaspool_shuffler_if.master bus
);

  localparam int unsigned IDXW = (w <= 2) ? 1 : $clog2(w);
  localparam int unsigned KW   = $clog2(w + 1);
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, EMIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [w-1:0]    perm_q [w];
  logic [w-1:0]    perm_d [w];
  logic [15:0]     lfsr_q, lfsr_d;
  logic [IDXW-1:0] i_q, i_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IDXW-1:0] r;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_en_q, wr_en_d;
  logic [w:0]      wr_index_q, wr_index_d;
  logic [w-1:0]    wr_value_q, wr_value_d;

  always_comb begin
    state_d = state_q;
    perm_d  = perm_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
    k_d     = k_q;
    r       = lfsr_q[IDXW-1:0];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          lfsr_d  = (bus.seed == '0) ? LFSR_DEFAULT : bus.seed;
        end
      end
      LOAD: begin
        for (int unsigned n = 0; n < w; n++) perm_d[n] = w'(1) << n;
        i_d     = IDXW'(w - 1);
        k_d     = '0;
        state_d = (w > 1) ? DRAW : EMIT;
      end
      DRAW: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // Rejection sampling keeps the draw uniform when w is not a power of two.
        if (r <= i_q) begin
          perm_d[i_q] = perm_q[r];
          perm_d[r]   = perm_q[i_q];
          i_d         = i_q - IDXW'(1);
          if (i_q == IDXW'(1)) begin
            state_d = EMIT;
            k_d     = '0;
          end
        end
      end
      EMIT: begin
        if (k_q == KW'(w)) state_d = DONE;
        else               k_d     = k_q + KW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in-cycle.
    busy_d     = (state_d == LOAD) || (state_d == DRAW) || (state_d == EMIT);
    done_d     = (state_d == DONE);
    wr_en_d    = (state_d == EMIT);
    wr_index_d = wr_en_d ? ((w + 1)'(1) << k_d) : '0;
    wr_value_d = '0;
    if (wr_en_d && (k_d < KW'(w))) wr_value_d = perm_d[k_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int unsigned n = 0; n < w; n++) perm_q[n] <= w'(1) << n;
      lfsr_q     <= LFSR_DEFAULT;
      i_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_index_q <= '0;
      wr_value_q <= '0;
    end else begin
      state_q    <= state_d;
      perm_q     <= perm_d;
      lfsr_q     <= lfsr_d;
      i_q        <= i_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_value_q <= wr_value_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_index = wr_index_q;
  assign bus.wr_value = wr_value_q;

endmodule

// File: tb/tb_biaspool_shuffler.sv
// Directed bench for biaspool_shuffler at w = 9, 1 and 4, with a bit-exact shuffle model
// used where hand-computing the permutation is impractical.
module tb_biaspool_shuffler;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  biaspool_shuffler_if #(.w(9)) bus9 ();
  biaspool_shuffler_if #(.w(1)) bus1 ();
  biaspool_shuffler_if #(.w(4)) bus4 ();

  biaspool_shuffler #(.w(9)) u_dut9 (.clock(clock), .reset(reset), .bus(bus9));
  biaspool_shuffler #(.w(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  biaspool_shuffler #(.w(4)) u_dut4 (.clock(clock), .reset(reset), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_vals  [10];
  int          exp_draws;
  logic [31:0] got_vals  [10];
  logic [31:0] got_idx   [10];
  logic [31:0] save_vals [10];
  int          save_draws;
  int          n_wr, got_draws, done_cnt;
  bit          completed;
  logic [3:0]  w4_vals [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ref_model(input int w, input logic [15:0] seed);
    logic [15:0] l;
    int perm [16];
    int i, r, idxw, t, guard;
    idxw = (w <= 2) ? 1 : $clog2(w);
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int n = 0; n < 16; n++) perm[n] = (n < w) ? (1 << n) : 0;
    i = w - 1;
    exp_draws = 0;
    guard = 0;
    while (i >= 1 && guard < 10000) begin
      r = int'(l) & ((1 << idxw) - 1);
      exp_draws++;
      if (r <= i) begin
        t = perm[i]; perm[i] = perm[r]; perm[r] = t;
        i--;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      guard++;
    end
    for (int n = 0; n < 10; n++) exp_vals[n] = (n < w) ? 32'(perm[n]) : 32'h0;
  endtask

  task automatic run9(input logic [15:0] sd, input bit pulse, input bit rst4);
    bit fin;
    fin = 0; completed = 0; n_wr = 0; got_draws = 0; done_cnt = 0;
    for (int n = 0; n < 10; n++) begin got_vals[n] = '0; got_idx[n] = '0; end
    bus9.seed = sd; bus9.start = 1'b1;
    tick();
    bus9.start = 1'b0;
    check("load_busy", 32'(bus9.busy), 1);
    check("load_wr_en", 32'(bus9.wr_en), 0);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      tick();
      bus9.start = 1'b0;
      bus9.seed  = sd;
      if (bus9.done) done_cnt++;
      if (bus9.wr_en) begin
        if (n_wr < 10) begin
          got_idx[n_wr]  = 32'(bus9.wr_index);
          got_vals[n_wr] = 32'(bus9.wr_value);
        end
        n_wr++;
        if (rst4 && n_wr == 4) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          check("rst_wr_en", 32'(bus9.wr_en), 0);
          check("rst_busy", 32'(bus9.busy), 0);
          check("rst_wr_index", 32'(bus9.wr_index), 0);
          fin = 1; completed = 1;
        end else if (pulse && n_wr == 3) begin
          bus9.start = 1'b1; bus9.seed = 16'hFFFF;
        end
      end else if (n_wr == 0) begin
        got_draws++;
        if (pulse && got_draws == 2) begin
          bus9.start = 1'b1; bus9.seed = 16'hFFFF;
        end
      end else begin
        check("done_after_last", 32'(bus9.done), 1);
        check("busy_at_done", 32'(bus9.busy), 0);
        fin = 1; completed = 1;
      end
    end
    if (!completed) check("run_timeout", 0, 1);
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus9.done) done_cnt++;
    end
  endtask

  task automatic verify(input string tg);
    logic [31:0] acc;
    acc = '0;
    check({tg, "_nwr"}, 32'(n_wr), 10);
    check({tg, "_draws"}, 32'(got_draws), 32'(exp_draws));
    check({tg, "_done_cnt"}, 32'(done_cnt), 1);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("%s_idx%0d", tg, n), got_idx[n], 32'(1) << n);
      check($sformatf("%s_val%0d", tg, n), got_vals[n], exp_vals[n]);
    end
    for (int n = 0; n < 9; n++) begin
      acc |= got_vals[n];
      check($sformatf("%s_onehot%0d", tg, n), 32'($countones(got_vals[n])), 1);
    end
    check({tg, "_cover"}, acc, 32'h1FF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    w4_vals = '{4'h8, 4'h1, 4'h4, 4'h2, 4'h0};
    reset = 1'b1;
    bus9.start = 1'b1; bus9.seed = 16'h0001;
    bus1.start = 1'b0; bus1.seed = 16'h0;
    bus4.start = 1'b0; bus4.seed = 16'h0;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_busy", 32'(bus9.busy), 0);
      check("rst_done", 32'(bus9.done), 0);
      check("rst_wr_en", 32'(bus9.wr_en), 0);
      check("rst_wr_index", 32'(bus9.wr_index), 0);
      check("rst_wr_value", 32'(bus9.wr_value), 0);
    end
    reset = 1'b0;
    bus9.start = 1'b0;
    tick();
    check("post_rst_busy", 32'(bus9.busy), 0);

    // seed 1 traced by hand: one rejection (r=8 at i=5), nine draw cycles
    exp_vals  = '{32'd256, 32'd128, 32'd8, 32'd64, 32'd32, 32'd1, 32'd16, 32'd4, 32'd2, 32'd0};
    exp_draws = 9;
    run9(16'h0001, 0, 0);
    verify("perm1");
    save_vals = got_vals; save_draws = got_draws;

    ref_model(9, 16'h0000);
    run9(16'h0000, 0, 0);
    verify("seed0");
    for (int n = 0; n < 10; n++) got_idx[n] = got_vals[n];
    got_draws = got_draws;
    begin
      logic [31:0] zero_vals [10];
      int zero_draws;
      zero_vals = got_vals; zero_draws = got_draws;
      run9(16'hACE1, 0, 0);
      verify("seedace1");
      for (int n = 0; n < 10; n++) check($sformatf("seed0_vs_ace1_%0d", n), got_vals[n], zero_vals[n]);
      check("seed0_vs_ace1_draws", 32'(got_draws), 32'(zero_draws));
    end

    ref_model(9, 16'h1234);
    run9(16'h1234, 1, 0);
    verify("busyprot");

    run9(16'h0001, 0, 1);
    check("rst_mid_no_done", 32'(done_cnt), 0);
    exp_vals  = '{32'd256, 32'd128, 32'd8, 32'd64, 32'd32, 32'd1, 32'd16, 32'd4, 32'd2, 32'd0};
    exp_draws = 9;
    run9(16'h0001, 0, 0);
    verify("after_rst");
    for (int n = 0; n < 10; n++) check($sformatf("after_rst_vs_perm1_%0d", n), got_vals[n], save_vals[n]);
    check("after_rst_vs_perm1_draws", 32'(got_draws), 32'(save_draws));

    bus1.seed = 16'h0005; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("w1_load_busy", 32'(bus1.busy), 1);
    check("w1_load_wr_en", 32'(bus1.wr_en), 0);
    tick();
    check("w1_wr0_en", 32'(bus1.wr_en), 1);
    check("w1_wr0_idx", 32'(bus1.wr_index), 32'h1);
    check("w1_wr0_val", 32'(bus1.wr_value), 32'h1);
    tick();
    check("w1_wr1_en", 32'(bus1.wr_en), 1);
    check("w1_wr1_idx", 32'(bus1.wr_index), 32'h2);
    check("w1_wr1_val", 32'(bus1.wr_value), 32'h0);
    tick();
    check("w1_done", 32'(bus1.done), 1);
    check("w1_done_busy", 32'(bus1.busy), 0);
    check("w1_done_wr_en", 32'(bus1.wr_en), 0);
    tick();
    check("w1_done_pulse", 32'(bus1.done), 0);

    // seed 1, w=4 by hand: swaps (3,1), (2,2), (1,0) give {8,1,4,2}
    bus4.seed = 16'h0001; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    check("w4_load_busy", 32'(bus4.busy), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("w4_draw%0d_wr_en", c), 32'(bus4.wr_en), 0);
      check($sformatf("w4_draw%0d_busy", c), 32'(bus4.busy), 1);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("w4_wr%0d_en", k), 32'(bus4.wr_en), 1);
      check($sformatf("w4_wr%0d_idx", k), 32'(bus4.wr_index), 32'(1) << k);
      check($sformatf("w4_wr%0d_val", k), 32'(bus4.wr_value), 32'(w4_vals[k]));
    end
    tick();
    check("w4_done", 32'(bus4.done), 1);
    check("w4_done_busy", 32'(bus4.busy), 0);
    check("w4_done_wr_en", 32'(bus4.wr_en), 0);
    tick();
    check("w4_done_pulse", 32'(bus4.done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
